// File: rtl/mem_stage_pipe.sv
// Execute-to-memory pipeline register with valid/ready handshake.
// SKID=1 uses a two-entry skid buffer with registered ready; SKID=0 uses one register with pass-through ready.
module mem_stage_pipe #(
  parameter int WIDTH = 32,
  parameter int RW    = 4,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [RW-1:0]    WA3E,
  input  logic             PCSrcE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemtoRegE,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [RW-1:0]    WA3M,
  output logic             PCSrcM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM,
  output logic [1:0]       occupancy
);

  typedef struct packed {
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] wd;
    logic [RW-1:0]    wa3;
    logic             pcsrc;
    logic             regwrite;
    logic             memwrite;
    logic             memtoreg;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam bit USE_SKID = (SKID != 0);

  state_t state, state_next;
  entry_t in_entry, main_q, skid_q;
  logic   accept, emit;
  logic   load_main, load_skid, shift_skid;

  assign in_entry = '{alu: ALUResultE, wd: WriteDataE, wa3: WA3E, pcsrc: PCSrcE,
                      regwrite: RegWriteE, memwrite: MemWriteE, memtoreg: MemtoRegE};

  assign out_valid = (state != EMPTY);
  assign occupancy = state;

  // Gating with reset keeps ready low during reset and high as soon as it releases.
  always_comb begin
    if (USE_SKID) in_ready = reset & (state != FULL);
    else          in_ready = reset & (!out_valid | out_ready);
  end

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          load_main  = 1'b1;
          state_next = ONE;
        end
        ONE: begin
          if (accept && emit) begin
            load_main = 1'b1;
          end else if (accept && USE_SKID) begin
            load_skid  = 1'b1;
            state_next = FULL;
          end else if (emit) begin
            state_next = EMPTY;
          end
        end
        FULL: if (emit) begin
          shift_skid = 1'b1;
          state_next = ONE;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_next;
  end

  // NOTE: entry registers are reset too, because the M data outputs must read zero during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)       main_q <= in_entry;
      else if (shift_skid) main_q <= skid_q;
      if (load_skid)       skid_q <= in_entry;
    end
  end

  assign ALUResultM = main_q.alu;
  assign WriteDataM = main_q.wd;
  assign WA3M       = main_q.wa3;
  // Control bits become a bubble whenever nothing valid is presented.
  assign PCSrcM     = main_q.pcsrc    & out_valid;
  assign RegWriteM  = main_q.regwrite & out_valid;
  assign MemWriteM  = main_q.memwrite & out_valid;
  assign MemtoRegM  = main_q.memtoreg & out_valid;

endmodule

// File: doc/mem_stage_pipe.md
MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 Parameter WIDTH, default 32, shall set the width of the ALU-result and write-data paths.
REQ-002 Parameter RW, default 4, shall set the width of the destination-register address.
REQ-003 Parameter SKID, default 1: 1 selects a two-entry skid buffer; 0 selects a single register with combinational ready.
REQ-004 Port clk, in, 1: the only clock; all state updates on its rising edge.
REQ-005 Port reset, in, 1: asynchronous, active-low reset.
REQ-006 Port flush, in, 1: synchronous kill of all held entries.
REQ-007 Port in_valid, in, 1: the execute stage presents an entry.
REQ-008 Port in_ready, out, 1: the block accepts an entry this cycle.
REQ-009 Ports ALUResultE and WriteDataE, in, WIDTH each: execute-stage data.
REQ-010 Port WA3E, in, RW: execute-stage destination register.
REQ-011 Ports PCSrcE, RegWriteE, MemWriteE and MemtoRegE, in, 1 each: execute-stage control.
REQ-012 Port out_valid, out, 1: the memory-stage entry is valid.
REQ-013 Port out_ready, in, 1: the memory stage consumes the entry.
REQ-014 Ports ALUResultM, WriteDataM (WIDTH), WA3M (RW) and PCSrcM, RegWriteM, MemWriteM, MemtoRegM (1 each), out: the head entry.
REQ-015 Port occupancy, out, 2: number of entries held (0..2).

Function
REQ-016 Accept shall occur when in_valid & in_ready at a clk edge; emit shall occur when out_valid & out_ready at a clk edge.
REQ-017 With SKID=1, the block shall implement states EMPTY (occ 0), ONE (main register valid) and FULL (main and skid valid).
REQ-018 With SKID=1, in_ready shall equal !FULL, registered and independent of out_ready; with SKID=0, in_ready shall equal !out_valid | out_ready.
REQ-019 EMPTY shall go to ONE on accept; otherwise it shall stay EMPTY.
REQ-020 ONE shall stay ONE on accept+emit (new entry into main) and on no accept and no emit.
REQ-021 ONE shall go to EMPTY on emit only, and to FULL on accept without emit (entry into skid).
REQ-022 FULL shall go to ONE on emit, with the skid entry moving into main in the same edge; no accept is possible in FULL.
REQ-023 Order shall be preserved: entries are emitted strictly in acceptance order, and none is dropped or duplicated.
REQ-024 Latency shall be one cycle from accept to out_valid with the entry visible.
REQ-025 Sustained throughput shall be one entry per cycle while out_ready=1.
REQ-026 PCSrcM, RegWriteM, MemWriteM and MemtoRegM shall be forced to 0 whenever out_valid=0 (bubble); ALUResultM, WriteDataM and WA3M shall hold their last value when invalid.
REQ-027 On flush, the next state shall be EMPTY regardless of in_valid, out_ready or current state; a simultaneous accept shall be discarded.
REQ-028 On flush, an emit in the same cycle shall still count as consumed by the memory stage.
REQ-029 occupancy shall equal 0, 1 or 2 for EMPTY, ONE or FULL respectively; with SKID=0 it shall never exceed 1.
REQ-030 Data shall be transferred bit-exact with no arithmetic or width conversion.

Reset
REQ-031 While reset=0: out_valid=0, in_ready=0, occupancy=0, all M outputs=0, state=EMPTY, independent of clk.
REQ-032 in_ready shall be 1 in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-operation shall discard all held entries immediately, with no partial emit.

Verification
REQ-034 Scenario: reset, then accept {ALUResultE=0x0000_00A5, WriteDataE=0x1234_5678, WA3E=4'h3, RegWriteE=1} with out_ready=1 -> next cycle out_valid=1, ALUResultM=0xA5, WA3M=3, RegWriteM=1, occupancy=1.
REQ-035 Scenario: stream 5 entries back-to-back with out_ready=1 -> 5 consecutive valid outputs in order, in_ready constantly 1.
REQ-036 Scenario: out_ready=0 while accepting A then B -> occupancy 2, in_ready=0; raise out_ready -> A then B emitted on consecutive cycles.
REQ-037 Scenario: FULL with MemWriteE=1 entries, then flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, MemWriteM=0, in_ready=1.
REQ-038 Scenario: assert reset=0 asynchronously between clk edges while in ONE -> outputs zero before the next clk edge.
REQ-039 Scenario: SKID=0, out_ready=0, out_valid=1 -> in_ready=0; toggle out_ready=1 -> in_ready=1 in the same cycle.
